lsu_controller: RTL and testbench
=================================

// Module: lsu_controller
// PURPOSE
//  Sequences data-memory accesses for load/store instructions decoded by the controller.
//  Sits between the core datapath (address from ALU, store data from rs2) and a
//  variable-latency data memory with a req/ack handshake. Stalls the core until the
//  access completes. Generates byte enables, store-lane alignment and load
//  sign/zero extension from funct3. Detects misaligned and illegal accesses.
// PARAMETERS
//  TIMEOUT_CYC  16  cycles in BUSY without mem_ack before bus error (LSU_TIMEOUT_EN only)
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst         in   1   synchronous reset, active-high
//  lsu_req     in   1   load/store in execute; held stable by core while stall=1
//  lsu_we      in   1   1=store, 0=load
//  funct3      in   3   access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
//  addr        in   32  byte address (ALU result)
//  wdata       in   32  store data (rs2), value in low bits
//  stall       out  1   freeze PC/pipeline
//  done        out  1   one-cycle pulse: access finished (ok or fault)
//  rdata       out  32  extended load data, valid while done=1
//  misaligned  out  1   fault flag, valid while done=1
//  bus_err     out  1   timeout flag, valid while done=1
//  mem_req     out  1   memory request, registered
//  mem_we      out  1   memory write enable, registered
//  mem_addr    out  32  word address {addr[31:2],2'b00}, registered
//  mem_wdata   out  32  lane-replicated store data, registered
//  mem_be      out  4   byte enables, registered
//  mem_ack     in   1   memory completes; may assert in the first mem_req cycle
//  mem_rdata   in   32  read word, valid with mem_ack
// BEHAVIOUR
//  Reset: state=IDLE. mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
//   done=0, rdata=0, misaligned=0, bus_err=0. Counter=0.
//  FSM states: IDLE, BUSY, RESP.
//  IDLE with lsu_req=1 and access legal: latch we/funct3/addr[1:0]. Drive mem_* regs. Go to BUSY.
//  IDLE with lsu_req=1 and access illegal: no memory access. Go to RESP with misaligned=1.
//   Illegal means h with addr[0]=1, w with addr[1:0]!=0, funct3 in {011,110,111},
//   or a store with funct3[2]=1.
//  BUSY: hold mem_req=1 and all mem_* stable until mem_ack=1 is sampled.
//   On ack: capture extended load data into rdata, deassert mem_req, go to RESP.
//  RESP: done=1 for exactly one cycle, then IDLE unconditionally.
//   The core advances this cycle, so a new lsu_req is first seen in the following IDLE cycle.
//  stall = lsu_req & (state != RESP). This is combinational.
//  Minimum latency with ack in the first mem_req cycle:
//   cycle0 IDLE, cycle1 BUSY, cycle2 RESP. The core stalls for 2 cycles.
//  Byte enables: b -> 4'b0001<<addr[1:0]. h -> 4'b0011<<addr[1:0]. w -> 4'b1111.
//  Store lanes: b -> {4{wdata[7:0]}}. h -> {2{wdata[15:0]}}. w -> wdata.
//  Load extract: select byte/half by latched addr[1:0].
//   b/h are sign-extended; bu/hu are zero-extended.
//  rdata=0 for stores and faults. misaligned and bus_err are cleared on leaving RESP.
//  lsu_req=0 in IDLE: outputs hold reset values except rdata, which keeps its last value.
//  mem_ack outside BUSY is ignored.
//  Reset mid-access wins: next edge IDLE, mem_req=0. The abandoned request is not retried.
// CONFIGURATION
//  LSU_TIMEOUT_EN defined:
//   Counter clears on entering BUSY and increments each BUSY cycle without ack.
//   When count reaches TIMEOUT_CYC-1 with no ack: drop mem_req, go to RESP with bus_err=1, rdata=0.
//   An ack in that same cycle takes priority; no error is raised.
//  LSU_TIMEOUT_EN undefined:
//   BUSY waits indefinitely. bus_err tied 0. No counter logic.
// TESTING
//  Aligned lw, addr=0x104, ack in first req cycle, mem_rdata=0xDEADBEEF
//   -> mem_be=1111, mem_addr=0x104, done in cycle2, rdata=0xDEADBEEF, stall 2 cycles.
//  sb, addr=0x103, wdata=0x000000A5, ack after 3 cycles
//   -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_req stable 4 cycles, done once.
//  lb at addr[1:0]=2, mem_rdata=0x0080_0000 -> rdata=0xFFFFFF80.
//   Same with lbu -> rdata=0x00000080.
//  lw, addr=0x102 -> no mem_req, done next cycle with misaligned=1.
//   funct3=011 -> same response.
//  rst=1 while in BUSY -> next edge mem_req=0, stall=0 (lsu_req=0), no done.
//   A new lw afterwards completes normally.
//  LSU_TIMEOUT_EN, TIMEOUT_CYC=16, no ack -> mem_req high 16 cycles, then done with bus_err=1.
//   Ack on cycle 16 -> bus_err=0.

Source files
------------

// File: rtl/lsu_controller.sv
// Load/store sequencer between the core and a req/ack data memory.
// Optional LSU_TIMEOUT_EN adds a BUSY watchdog that raises bus_err.
module lsu_controller #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lo_q, lo_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        done_q, done_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_err_q, bus_err_d;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYC != 0);
`endif

    logic        illegal;
    logic [3:0]  be_new;
    logic [31:0] lane_new;
    logic [15:0] shifted;
    logic [31:0] ext;

    // Half needs addr[0]=0, word needs addr[1:0]=0; unsigned sizes are loads only.
    always_comb begin
        illegal = 1'b0;
        unique case (1'b1)
            (funct3 == 3'b011),
            (funct3 == 3'b110),
            (funct3 == 3'b111):               illegal = 1'b1;
            (funct3 == 3'b001 && addr[0]),
            (funct3 == 3'b101 && addr[0]):    illegal = 1'b1;
            (funct3 == 3'b010 && addr[1:0] != 2'b00): illegal = 1'b1;
            default:                          illegal = 1'b0;
        endcase
        if (lsu_we && funct3[2]) begin
            illegal = 1'b1;
        end
    end

    always_comb begin
        be_new   = 4'b1111;
        lane_new = wdata;
        unique case (funct3[1:0])
            2'b00: begin
                be_new   = 4'b0001 << addr[1:0];
                lane_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_new   = 4'b0011 << addr[1:0];
                lane_new = {2{wdata[15:0]}};
            end
            default: begin
                be_new   = 4'b1111;
                lane_new = wdata;
            end
        endcase
    end

    always_comb begin
        shifted = 16'(mem_rdata >> {lo_q, 3'b000});
        ext     = mem_rdata;
        unique case (f3_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ext = {24'h0, shifted[7:0]};
            3'b101:  ext = {16'h0, shifted[15:0]};
            default: ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        lo_d        = lo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        done_d      = done_q;
        rdata_d     = rdata_q;
        mis_d       = mis_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = cnt_q;
        bus_err_d   = bus_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (lsu_req && illegal) begin
                    mis_d   = 1'b1;
                    rdata_d = 32'h0;
                    done_d  = 1'b1;
                    state_d = RESP;
                end else if (lsu_req) begin
                    we_d        = lsu_we;
                    f3_d        = funct3;
                    lo_d        = addr[1:0];
                    mem_req_d   = 1'b1;
                    mem_we_d    = lsu_we;
                    mem_addr_d  = {addr[31:2], 2'b00};
                    mem_wdata_d = lane_new;
                    mem_be_d    = be_new;
`ifdef LSU_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    rdata_d     = we_q ? 32'h0 : ext;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'h0;
                    mem_wdata_d = 32'h0;
                    mem_be_d    = 4'b0000;
                    done_d      = 1'b1;
                    state_d     = RESP;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    rdata_d     = 32'h0;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'h0;
                    mem_wdata_d = 32'h0;
                    mem_be_d    = 4'b0000;
                    bus_err_d   = 1'b1;
                    done_d      = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                done_d  = 1'b0;
                mis_d   = 1'b0;
`ifdef LSU_TIMEOUT_EN
                bus_err_d = 1'b0;
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            lo_q        <= 2'b00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'b0000;
            done_q      <= 1'b0;
            rdata_q     <= 32'h0;
            mis_q       <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            lo_q        <= lo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            mis_q       <= mis_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= cnt_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    // The core is released in RESP so it can advance while done is shown.
    assign stall      = lsu_req & (state_q != RESP);
    assign done       = done_q;
    assign rdata      = rdata_q;
    assign misaligned = mis_q;
`ifdef LSU_TIMEOUT_EN
    assign bus_err    = bus_err_q;
`else
    assign bus_err    = 1'b0;
`endif
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;

endmodule

// File: tb/tb_lsu_controller.sv
// Directed self-checking bench for lsu_controller.
// Define LSU_TIMEOUT_EN for both files to exercise the watchdog.
module tb_lsu_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req, lsu_we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, misaligned, bus_err;
    logic [31:0] rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int failures = 0;

    int          r_req, r_stall, r_done, r_dcyc;
    logic [31:0] r_rdata, r_addr, r_wdata;
    logic        r_mis, r_berr, r_we, r_unstable;
    logic [3:0]  r_be;

    lsu_controller dut (
        .clk        (clk),
        .rst        (rst),
        .lsu_req    (lsu_req),
        .lsu_we     (lsu_we),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .done       (done),
        .rdata      (rdata),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one access; memory acks after ack_after unacked req cycles.
    task automatic run_access(input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int ack_after, input logic [31:0] rd);
        r_req = 0; r_stall = 0; r_done = 0; r_dcyc = -1;
        r_rdata = 32'hx; r_mis = 1'bx; r_berr = 1'bx; r_unstable = 1'b0;
        r_be = 4'h0; r_addr = 32'h0; r_wdata = 32'h0; r_we = 1'b0;
        lsu_req = 1'b1; lsu_we = we; funct3 = f3; addr = a; wdata = wd;
        mem_rdata = rd; mem_ack = 1'b0;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (stall) r_stall++;
            if (mem_req) begin
                if (r_req == 0) begin
                    r_be = mem_be; r_addr = mem_addr;
                    r_wdata = mem_wdata; r_we = mem_we;
                end else if (mem_be !== r_be || mem_addr !== r_addr ||
                             mem_wdata !== r_wdata || mem_we !== r_we) begin
                    r_unstable = 1'b1;
                end
                r_req++;
                mem_ack = (r_req > ack_after);
            end else begin
                mem_ack = 1'b0;
            end
            if (done) begin
                r_done++; r_dcyc = c; r_rdata = rdata;
                r_mis = misaligned; r_berr = bus_err;
                lsu_req = 1'b0;
            end
            tick();
            mem_ack = 1'b0;
            if (r_done > 0) begin
                #1;
                if (done) r_done++;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; lsu_req = 1'b0; lsu_we = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_be, done, misaligned, bus_err, stall} !== 10'b0) begin
            failures++;
            $display("FAIL reset_flags: got req=%b we=%b be=%b done=%b mis=%b berr=%b stall=%b required all 0",
                     mem_req, mem_we, mem_be, done, misaligned, bus_err, stall);
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h required 0",
                     mem_addr, mem_wdata, rdata);
        end
    endtask

    task automatic test_lw();
        run_access(1'b0, 3'b010, 32'h104, 32'h0, 0, 32'hDEADBEEF);
        checks++;
        if (r_be !== 4'b1111 || r_addr !== 32'h104 || r_we !== 1'b0) begin
            failures++;
            $display("FAIL lw_req: got be=%b addr=%h we=%b required 1111 00000104 0", r_be, r_addr, r_we);
        end
        checks++;
        if (r_dcyc != 2 || r_stall != 2 || r_req != 1) begin
            failures++;
            $display("FAIL lw_timing: got done_cyc=%0d stall=%0d req=%0d required 2 2 1", r_dcyc, r_stall, r_req);
        end
        checks++;
        if (r_rdata !== 32'hDEADBEEF || r_done != 1 || r_mis !== 1'b0 || r_berr !== 1'b0) begin
            failures++;
            $display("FAIL lw_resp: got rdata=%h done=%0d mis=%b berr=%b required deadbeef 1 0 0",
                     r_rdata, r_done, r_mis, r_berr);
        end
        checks++;
        if (rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL lw_rdata_hold: got %h required deadbeef", rdata);
        end
    endtask

    task automatic test_sb();
        run_access(1'b1, 3'b000, 32'h103, 32'h000000A5, 3, 32'h0);
        checks++;
        if (r_be !== 4'b1000 || r_wdata !== 32'hA5A5A5A5 || r_addr !== 32'h100 || r_we !== 1'b1) begin
            failures++;
            $display("FAIL sb_req: got be=%b wdata=%h addr=%h we=%b required 1000 a5a5a5a5 00000100 1",
                     r_be, r_wdata, r_addr, r_we);
        end
        checks++;
        if (r_req != 4 || r_unstable !== 1'b0 || r_done != 1 || r_rdata !== 32'h0) begin
            failures++;
            $display("FAIL sb_resp: got req=%0d unstable=%b done=%0d rdata=%h required 4 0 1 0",
                     r_req, r_unstable, r_done, r_rdata);
        end
    endtask

    task automatic test_sh();
        run_access(1'b1, 3'b001, 32'h206, 32'hFFFF1234, 1, 32'h0);
        checks++;
        if (r_be !== 4'b1100 || r_wdata !== 32'h12341234 || r_addr !== 32'h204 || r_req != 2) begin
            failures++;
            $display("FAIL sh_req: got be=%b wdata=%h addr=%h req=%0d required 1100 12341234 00000204 2",
                     r_be, r_wdata, r_addr, r_req);
        end
    endtask

    task automatic test_load_ext();
        run_access(1'b0, 3'b000, 32'h42, 32'h0, 0, 32'h00800000);
        checks++;
        if (r_rdata !== 32'hFFFFFF80 || r_be !== 4'b0100) begin
            failures++;
            $display("FAIL lb_ext: got rdata=%h be=%b required ffffff80 0100", r_rdata, r_be);
        end
        run_access(1'b0, 3'b100, 32'h42, 32'h0, 0, 32'h00800000);
        checks++;
        if (r_rdata !== 32'h00000080) begin
            failures++;
            $display("FAIL lbu_ext: got rdata=%h required 00000080", r_rdata);
        end
        run_access(1'b0, 3'b001, 32'h42, 32'h0, 2, 32'h80017F00);
        checks++;
        if (r_rdata !== 32'hFFFF8001 || r_be !== 4'b1100) begin
            failures++;
            $display("FAIL lh_ext: got rdata=%h be=%b required ffff8001 1100", r_rdata, r_be);
        end
        run_access(1'b0, 3'b101, 32'h42, 32'h0, 0, 32'h80017F00);
        checks++;
        if (r_rdata !== 32'h00008001) begin
            failures++;
            $display("FAIL lhu_ext: got rdata=%h required 00008001", r_rdata);
        end
    endtask

    task automatic test_misaligned();
        logic [2:0]  f3v [4] = '{3'b010, 3'b011, 3'b001, 3'b100};
        logic [31:0] av  [4] = '{32'h102, 32'h100, 32'h101, 32'h100};
        logic        wev [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_access(wev[i], f3v[i], av[i], 32'h55, 0, 32'hFFFFFFFF);
            checks++;
            if (r_req != 0 || r_dcyc != 1 || r_done != 1 || r_mis !== 1'b1 || r_rdata !== 32'h0) begin
                failures++;
                $display("FAIL misaligned_%0d: got req=%0d done_cyc=%0d done=%0d mis=%b rdata=%h required 0 1 1 1 0",
                         i, r_req, r_dcyc, r_done, r_mis, r_rdata);
            end
        end
        checks++;
        if (misaligned !== 1'b0) begin
            failures++;
            $display("FAIL misaligned_clear: got %b required 0", misaligned);
        end
    endtask

    task automatic test_idle_ack();
        lsu_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick(); tick();
        checks++;
        if (done !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL idle_ack: got done=%b req=%b stall=%b required 0 0 0", done, mem_req, stall);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        lsu_req = 1'b1; lsu_we = 1'b0; funct3 = 3'b010; addr = 32'h300; mem_ack = 1'b0;
        tick();
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_busy: got req=%b required 1", mem_req);
        end
        rst = 1'b1; lsu_req = 1'b0;
        tick();
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: got req=%b stall=%b done=%b required 0 0 0", mem_req, stall, done);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (mem_req !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_noretry: got req=%b done=%b required 0 0", mem_req, done);
        end
        run_access(1'b0, 3'b010, 32'h300, 32'h0, 1, 32'hCAFEF00D);
        checks++;
        if (r_rdata !== 32'hCAFEF00D || r_done != 1 || r_dcyc != 3) begin
            failures++;
            $display("FAIL rst_mid_after: got rdata=%h done=%0d done_cyc=%0d required cafef00d 1 3",
                     r_rdata, r_done, r_dcyc);
        end
    endtask

    task automatic test_back_to_back();
        lsu_req = 1'b1; lsu_we = 1'b0; funct3 = 3'b010; addr = 32'h10; mem_ack = 1'b0;
        mem_rdata = 32'h11112222;
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (done !== 1'b1 || stall !== 1'b0) begin
            failures++;
            $display("FAIL b2b_resp: got done=%b stall=%b required 1 0", done, stall);
        end
        lsu_we = 1'b1; addr = 32'h200; wdata = 32'h0BADBEEF;
        tick();
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: got req=%b stall=%b done=%b required 0 1 0", mem_req, stall, done);
        end
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'h0BADBEEF) begin
            failures++;
            $display("FAIL b2b_second: got req=%b we=%b addr=%h wdata=%h required 1 1 00000200 0badbeef",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        lsu_req = 1'b0;
        checks++;
        if (done !== 1'b1 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL b2b_done: got done=%b rdata=%h required 1 0", done, rdata);
        end
        tick();
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        run_access(1'b0, 3'b010, 32'h400, 32'h0, 1000, 32'h77777777);
        checks++;
        if (r_req != 16 || r_done != 1 || r_berr !== 1'b1 || r_rdata !== 32'h0) begin
            failures++;
            $display("FAIL timeout: got req=%0d done=%0d berr=%b rdata=%h required 16 1 1 0",
                     r_req, r_done, r_berr, r_rdata);
        end
        checks++;
        if (bus_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear: got %b required 0", bus_err);
        end
        run_access(1'b0, 3'b010, 32'h400, 32'h0, 15, 32'h77777777);
        checks++;
        if (r_req != 16 || r_berr !== 1'b0 || r_rdata !== 32'h77777777) begin
            failures++;
            $display("FAIL timeout_ack_wins: got req=%0d berr=%b rdata=%h required 16 0 77777777",
                     r_req, r_berr, r_rdata);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lw();
        test_sb();
        test_sh();
        test_load_ext();
        test_misaligned();
        test_idle_ack();
        test_reset_mid();
        test_back_to_back();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
